// File: rtl/coloring_recorder.sv
// Pairs each colour sample with the checker's verdict one cycle later, queues accepted colours in a show-ahead FIFO.
// Optional reject counter and overflow flag are built only when `COLOR_REC_STATS_EN is defined.
`timescale 1ns/1ps
module coloring_recorder #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               color,
  input  logic                     check,
  input  logic                     rd_en,
  output logic [1:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNTW-1:0]          rej_cnt,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [1:0]    color_d_q;
  logic          pend_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [1:0]    mem_q [DEPTH];
  logic          accept, reject, pop, push, drop;

  always_comb begin
    accept   = pend_q & ~check;
    reject   = pend_q & check;
    pop      = rd_en & (count_q != '0);
    // A full FIFO can still take a push when the head leaves on the same edge.
    push     = accept & ((count_q != FULL_CNT) | pop);
    drop     = accept & ~push;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_d_q <= 2'b00;
      pend_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      color_d_q <= color;
      pend_q    <= 1'b1;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= color_d_q;
  end

  assign rd_data = (count_q == '0) ? 2'b00 : mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;

`ifdef COLOR_REC_STATS_EN
  logic [CNTW-1:0] rej_q, rej_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    rej_d = rej_q;
    if (reject && (rej_q != '1)) rej_d = rej_q + CNTW'(1);
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rej_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rej_q <= rej_d;
      ovf_q <= ovf_d;
    end
  end

  assign rej_cnt  = rej_q;
  assign overflow = ovf_q;
`else
  logic stats_unused;
  assign stats_unused = reject | drop;
  assign rej_cnt      = '0;
  assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_coloring_recorder.sv
// Directed bench for coloring_recorder: accept/reject paths, overflow, full push+pop, saturation, async reset.
`timescale 1ns/1ps
module tb_coloring_recorder;
  localparam int DEPTH = 8;
`ifdef COLOR_REC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] color = 2'b00;
  logic       check = 1'b0;
  logic       rd_en = 1'b0;

  logic [1:0] rd_data, rd_data2;
  logic       empty, full, overflow, empty2, full2, overflow2;
  logic [3:0] count, count2;
  logic [7:0] rej_cnt;
  logic [1:0] rej_sat;

  coloring_recorder #(.DEPTH(DEPTH), .CNTW(8)) u_dut (
    .clk(clk), .reset(reset), .color(color), .check(check), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .rej_cnt(rej_cnt), .overflow(overflow)
  );

  coloring_recorder #(.DEPTH(DEPTH), .CNTW(2)) u_sat (
    .clk(clk), .reset(reset), .color(color), .check(check), .rd_en(rd_en),
    .rd_data(rd_data2), .empty(empty2), .full(full2), .count(count2),
    .rej_cnt(rej_sat), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] mq[$];
  logic       m_pend;
  logic [1:0] m_cd;
  int         m_rej, m_rej2;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 1'b0;
    m_cd   = 2'b00;
    m_rej  = 0;
    m_rej2 = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_all();
    logic [1:0] head;
    head = (mq.size() > 0) ? mq[0] : 2'b00;
    chk("count",     count,     mq.size());
    chk("empty",     empty,     mq.size() == 0);
    chk("full",      full,      mq.size() == DEPTH);
    chk("rd_data",   rd_data,   head);
    chk("rej_cnt",   rej_cnt,   STATS ? m_rej : 0);
    chk("overflow",  overflow,  STATS ? m_ovf : 0);
    chk("count2",    count2,    mq.size());
    chk("empty2",    empty2,    mq.size() == 0);
    chk("full2",     full2,     mq.size() == DEPTH);
    chk("rd_data2",  rd_data2,  head);
    chk("rej_sat",   rej_sat,   STATS ? m_rej2 : 0);
    chk("overflow2", overflow2, STATS ? m_ovf : 0);
  endtask

  // Drive one cycle of inputs, update the reference queue at the edge, check at the falling edge.
  task automatic step(input logic [1:0] c, input logic k, input logic r);
    bit pop, was_full;
    color = c;
    check = k;
    rd_en = r;
    @(posedge clk);
    pop      = r && (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (m_pend) begin
      if (!k) begin
        if (was_full && !pop) m_ovf = 1'b1;
        else mq.push_back(m_cd);
      end else begin
        if (m_rej < 255) m_rej++;
        if (m_rej2 < 3) m_rej2++;
      end
    end
    m_cd   = c;
    m_pend = 1'b1;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    reset = 1'b0;
    #1;
  endtask

  logic [1:0] ov [9] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
  logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Accept path
    step(2'd1, 1'b0, 1'b0);
    chk("acc_first_edge_count", count, 0);
    step(2'd2, 1'b0, 1'b0);
    step(2'd3, 1'b0, 1'b0);
    step(2'd0, 1'b0, 1'b0);
    chk("acc_count", count, 3);
    chk("acc_head", rd_data, 1);
    step(2'd0, 1'b1, 1'b1);
    chk("acc_pop1", rd_data, 2);
    step(2'd0, 1'b1, 1'b1);
    chk("acc_pop2", rd_data, 3);
    step(2'd0, 1'b1, 1'b1);
    chk("acc_empty", empty, 1);
    step(2'd0, 1'b1, 1'b1);
    chk("acc_pop_empty", count, 0);

    // Reject path; check on the capture edge must be ignored
    do_reset();
    step(2'd0, 1'b1, 1'b0);
    chk("rej_ignored", rej_cnt, 0);
    step(2'd0, 1'b1, 1'b0);
    chk("rej_count", count, 0);
    chk("rej_cnt", rej_cnt, STATS ? 1 : 0);

    // Overflow: nine accepts into eight entries
    do_reset();
    for (int i = 0; i < 9; i++) step(ov[i], 1'b0, 1'b0);
    step(2'd0, 1'b0, 1'b0);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, STATS ? 1 : 0);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_head", rd_data, ov[i]);
      step(2'd0, 1'b1, 1'b1);
    end
    chk("ovf_ninth_absent", empty, 1);

    // Full with simultaneous push and pop
    do_reset();
    repeat (8) step(2'd1, 1'b0, 1'b0);
    step(2'd2, 1'b0, 1'b0);
    chk("fpp_full", full, 1);
    step(2'd0, 1'b0, 1'b1);
    chk("fpp_count", count, 8);
    chk("fpp_no_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      chk("fpp_head", rd_data, (i == 7) ? 2 : 1);
      step(2'd0, 1'b1, 1'b1);
    end
    chk("fpp_empty", empty, 1);

    // Saturation of the 2-bit counter
    do_reset();
    step(2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(2'd0, 1'b1, 1'b0);
      chk("sat_seq", rej_sat, STATS ? sat_exp[i] : 0);
    end

    // Asynchronous reset between edges
    do_reset();
    step(2'd1, 1'b0, 1'b0);
    repeat (4) step(2'd2, 1'b0, 1'b0);
    step(2'd3, 1'b1, 1'b0);
    chk("ar_count_before", count, 4);
    color = 2'd3;
    check = 1'b0;
    rd_en = 1'b0;
    reset = 1'b1;
    #2;
    chk("ar_count", count, 0);
    chk("ar_empty", empty, 1);
    chk("ar_rej", rej_cnt, 0);
    chk("ar_ovf", overflow, 0);
    model_reset();
    reset = 1'b0;
    #1;
    step(2'd3, 1'b0, 1'b0);
    chk("ar_no_push", count, 0);
    step(2'd1, 1'b0, 1'b0);
    chk("ar_push_count", count, 1);
    chk("ar_push_data", rd_data, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
